// File: rtl/word_tx_pkg.sv
// Shared types and parameter checks for the word-to-byte UART serializer.
package word_tx_pkg;

  localparam int NB_BYTE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic bit is_pow2_min2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit word_fmt_ok(input int nb_word, input int nb_byte);
    return (nb_byte > 0) && (nb_word >= nb_byte) && ((nb_word % nb_byte) == 0);
  endfunction

endpackage

// File: rtl/word_tx_serializer_sync_fifo.sv
// Synchronous word FIFO with registered read data (head appears the cycle after pop).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo
  import word_tx_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != FULL_LVL) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign data_o  = rd_data_q;
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/word_tx_serializer.sv
// Buffers words and sends them byte by byte over a start/done UART handshake.
// Push-to-start is two clocks; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module word_tx_serializer
  import word_tx_pkg::*;
#(
  parameter  int NB_WORD = 32,
  parameter  int NB_BYTE = NB_BYTE_DEF,
  parameter  int DEPTH   = 64,
  localparam int NB_PTR  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_msb_first,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_PTR:0]    o_level,
  output logic               o_overflow,
  output logic               o_done
);

  localparam int BYTES  = NB_WORD / NB_BYTE;
  localparam int NB_CNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BYTES - 1);

  if (!word_fmt_ok(NB_WORD, NB_BYTE)) begin : g_bad_word
    $error("NB_WORD must be a positive multiple of NB_BYTE");
  end
  if (!is_pow2_min2(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  state_e             state_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_WORD-1:0] shift_q;
  logic [NB_WORD-1:0] shift_d;
  logic [NB_WORD-1:0] src_word;
  logic [NB_BYTE-1:0] byte_d;
  logic               msb_q;
  logic               tx_start_q;
  logic [NB_BYTE-1:0] tx_data_q;
  logic               done_q;
  logic               overflow_q;

  logic [NB_WORD-1:0] fifo_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [NB_PTR:0]    fifo_level;
  logic               fifo_pop;

  // Load from IDLE, or chain straight into the next word when the last byte completes.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == IDLE) ||
                     ((state_q == WAIT) && i_tx_done_tick && (cnt_q == LAST_CNT)));

  sync_fifo #(
    .WIDTH (NB_WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (i_push),
    .data_i  (i_word),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Byte 0 comes straight from the FIFO read register; later bytes from the shifted copy.
  always_comb begin
    src_word = (cnt_q == '0) ? fifo_data : shift_q;
    byte_d   = msb_q ? src_word[NB_WORD-1 -: NB_BYTE] : src_word[NB_BYTE-1:0];
    shift_d  = msb_q ? (src_word << NB_BYTE) : (src_word >> NB_BYTE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      msb_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (i_push && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            msb_q   <= i_msb_first;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= byte_d;
          shift_q    <= shift_d;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (i_tx_done_tick) begin
            if (cnt_q != LAST_CNT) begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= SEND;
            end else if (!fifo_empty) begin
              msb_q   <= i_msb_first;
              cnt_q   <= '0;
              state_q <= SEND;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_full     = fifo_full;
  assign o_empty    = fifo_empty && (state_q == IDLE);
  assign o_level    = fifo_level;
  assign o_overflow = overflow_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_word_tx_serializer.sv
// Directed bench for word_tx_serializer: 32-bit/64-entry and 64-bit/4-entry instances,
// byte-level scoreboard fed at push time and drained by a UART model.
module tb_word_tx_serializer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_push;
  logic [31:0] i_word;
  logic        i_msb_first;
  logic        tick_auto;
  logic        tick_man;
  logic        tick;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_full;
  logic        o_empty;
  logic [6:0]  o_level;
  logic        o_overflow;
  logic        o_done;

  logic        push64;
  logic [63:0] word64;
  logic        tick64;
  logic        start64;
  logic [7:0]  data64;
  logic        full64;
  logic        empty64;
  logic [2:0]  level64;
  logic        ovf64;
  logic        done64;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int dones = 0;
  int starts64 = 0;
  bit auto_en = 1'b1;
  bit busy = 1'b0;
  int wait_cnt = 0;
  bit busy64 = 1'b0;
  int wait64 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp64_q[$];
  logic [7:0] exp_b;
  logic [7:0] exp64_b;

  always #5 clk = ~clk;
  assign tick = tick_auto | tick_man;

  word_tx_serializer #(.NB_WORD(32), .NB_BYTE(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_push(i_push), .i_word(i_word), .i_msb_first(i_msb_first),
    .i_tx_done_tick(tick), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_full(o_full),
    .o_empty(o_empty), .o_level(o_level), .o_overflow(o_overflow), .o_done(o_done)
  );

  word_tx_serializer #(.NB_WORD(64), .NB_BYTE(8), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .i_push(push64), .i_word(word64), .i_msb_first(1'b1),
    .i_tx_done_tick(tick64), .o_tx_start(start64), .o_tx_data(data64), .o_full(full64),
    .o_empty(empty64), .o_level(level64), .o_overflow(ovf64), .o_done(done64)
  );

  // UART model + scoreboard for the 32-bit instance: done 10 cycles after each start.
  always @(negedge clk) begin
    tick_auto = 1'b0;
    if (o_done === 1'b1) dones++;
    if (o_tx_start === 1'b1) begin
      starts++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_start: got byte %0h, expected no start", o_tx_data);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        checks++;
        assert (o_tx_data === exp_b) else begin
          errors++;
          $error("FAIL tx_byte: got %0h, expected %0h", o_tx_data, exp_b);
        end
      end
      busy = 1'b1;
      wait_cnt = 0;
    end else if (reset === 1'b1) begin
      busy = 1'b0;
    end else if (busy && auto_en) begin
      wait_cnt++;
      if (wait_cnt == 10) begin
        tick_auto = 1'b1;
        busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    tick64 = 1'b0;
    if (start64 === 1'b1) begin
      starts64++;
      checks++;
      assert (exp64_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_start64: got byte %0h, expected no start", data64);
      end
      if (exp64_q.size() != 0) begin
        exp64_b = exp64_q.pop_front();
        checks++;
        assert (data64 === exp64_b) else begin
          errors++;
          $error("FAIL tx_byte64: got %0h, expected %0h", data64, exp64_b);
        end
      end
      busy64 = 1'b1;
      wait64 = 0;
    end else if (reset === 1'b1) begin
      busy64 = 1'b0;
    end else if (busy64) begin
      wait64++;
      if (wait64 == 10) begin
        tick64 = 1'b1;
        busy64 = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick_man = 1'b1;
    cycles(1);
    tick_man = 1'b0;
  endtask

  task automatic push32(input logic [31:0] w, input logic m, input bit accept);
    i_push = 1'b1;
    i_word = w;
    i_msb_first = m;
    cycles(1);
    i_push = 1'b0;
    if (accept) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(m ? w[31-8*k -: 8] : w[8*k +: 8]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, o_tx_start, 0);
    chk({tag, "_data"}, o_tx_data, 0);
    chk({tag, "_full"}, o_full, 0);
    chk({tag, "_empty"}, o_empty, 1);
    chk({tag, "_level"}, o_level, 0);
    chk({tag, "_overflow"}, o_overflow, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(o_empty === 1'b1 && exp_q.size() == 0) && n < budget) begin
      cycles(1);
      n++;
    end
    chk({tag, "_drained"}, (n < budget), 1);
    cycles(2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int n;
    reset = 1'b1;
    i_push = 1'b0;
    i_word = '0;
    i_msb_first = 1'b1;
    tick_man = 1'b0;
    push64 = 1'b0;
    word64 = '0;
    cycles(3);
    chk_reset("reset");
    reset = 1'b0;
    cycles(2);

    // 1: msb-first word, start two edges after the push
    s0 = starts; d0 = dones;
    push32(32'hAABBCCDD, 1'b1, 1'b1);
    chk("lat_edge1_start", o_tx_start, 0);
    cycles(1);
    chk("lat_edge2_start", o_tx_start, 0);
    cycles(1);
    chk("lat_start", o_tx_start, 1);
    chk("lat_data", o_tx_data, 8'hAA);
    wait_drain("msb", 500);
    chk("msb_starts", starts - s0, 4);
    chk("msb_done", dones - d0, 1);
    chk("msb_empty", o_empty, 1);

    // 2: lsb-first, then the 64-bit instance
    s0 = starts; d0 = dones;
    push32(32'hAABBCCDD, 1'b0, 1'b1);
    wait_drain("lsb", 500);
    chk("lsb_starts", starts - s0, 4);
    chk("lsb_done", dones - d0, 1);
    push64 = 1'b1;
    word64 = 64'h0102030405060708;
    cycles(1);
    push64 = 1'b0;
    for (int k = 0; k < 8; k++) exp64_q.push_back(8'(k + 1));
    n = 0;
    while (!(empty64 === 1'b1 && exp64_q.size() == 0) && n < 1000) begin
      cycles(1);
      n++;
    end
    chk("w64_drained", (n < 1000), 1);
    chk("w64_starts", starts64, 8);

    // 3: fill past full with the UART stalled, then drain in order
    auto_en = 1'b0;
    s0 = starts; d0 = dones;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push32({8'(i), 8'(i + 64), 8'(i + 128), 8'(~i)}, 1'b1, (i <= DEPTH));
      if (i == DEPTH - 1) begin
        chk("fill_notfull", o_full, 0);
        chk("fill_level_m1", o_level, DEPTH - 1);
      end
      if (i == DEPTH) begin
        chk("fill_full", o_full, 1);
        chk("fill_no_ovf", o_overflow, 0);
      end
    end
    chk("ovf_set", o_overflow, 1);
    chk("ovf_level", o_level, DEPTH);
    auto_en = 1'b1;
    wait_drain("fill", 6000);
    chk("fill_starts", starts - s0, 4 * (DEPTH + 1));
    chk("fill_done", dones - d0, 1);
    chk("ovf_sticky", o_overflow, 1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("ovf_cleared", o_overflow, 0);

    // 4: push while full in the same cycle the last byte completes
    auto_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push32(32'h10203040 + i, 1'b1, 1'b1);
    chk("full2_full", o_full, 1);
    for (int b = 0; b < 3; b++) begin
      tick_once();
      cycles(3);
    end
    i_push = 1'b1;
    i_word = 32'hCAFEF00D;
    tick_man = 1'b1;
    cycles(1);
    i_push = 1'b0;
    tick_man = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    chk("pushpop_level", o_level, DEPTH);
    chk("pushpop_ovf", o_overflow, 0);
    chk("pushpop_full", o_full, 1);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    exp_q.delete();

    // 5: reset while waiting on byte 2 with three words queued
    for (int i = 0; i < 4; i++) push32(32'h11223344 + (i << 4), 1'b1, 1'b1);
    cycles(3);
    tick_once();
    cycles(3);
    tick_once();
    cycles(3);
    chk("pre_rst_level", o_level, 3);
    reset = 1'b1;
    cycles(1);
    exp_q.delete();
    chk_reset("midrst");
    reset = 1'b0;
    s0 = starts;
    tick_once();
    cycles(6);
    chk("midrst_no_start", starts - s0, 0);
    chk("midrst_empty", o_empty, 1);

    // 6: done ticks while IDLE and while in SEND are ignored
    tick_once();
    cycles(4);
    chk("idle_tick_start", starts - s0, 0);
    chk("idle_tick_empty", o_empty, 1);
    d0 = dones;
    push32(32'h55667788, 1'b1, 1'b1);
    cycles(1);
    tick_once();
    chk("send_tick_start", o_tx_start, 1);
    chk("send_tick_data", o_tx_data, 8'h55);
    cycles(5);
    chk("send_tick_one", starts - s0, 1);
    auto_en = 1'b1;
    wait_drain("send_tick", 500);
    chk("send_tick_starts", starts - s0, 4);
    chk("send_tick_done", dones - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
